// File: rtl/writeback_commit.sv
// Writeback/commit stage: accepts one retired-instruction bundle, issues its memory
// destinations over a valid/ready write port, then commits GPRs, EFLAGS and EIP in one cycle.
module writeback_commit #(
    parameter logic [31:0] RESET_EIP    = 32'h0000_0000,
    parameter logic [31:0] RESET_EFLAGS = 32'h0000_0002
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_opnd0_w,
    input  logic [31:0]  in_opnd1_w,
    input  logic [31:0]  in_eflags,
    input  logic [31:0]  in_next_eip,
    input  logic [1:0]   in_dest0_kind,
    input  logic [2:0]   in_dest0_sel,
    input  logic [1:0]   in_dest0_width,
    input  logic [31:0]  in_dest0_addr,
    input  logic [1:0]   in_dest1_kind,
    input  logic [2:0]   in_dest1_sel,
    input  logic [1:0]   in_dest1_width,
    input  logic [31:0]  in_dest1_addr,
    output logic         mem_wr_valid,
    input  logic         mem_wr_ready,
    output logic [31:0]  mem_wr_addr,
    output logic [31:0]  mem_wr_data,
    output logic [3:0]   mem_wr_mask,
    output logic [255:0] gpr_flat,
    output logic [31:0]  eflags_q,
    output logic [31:0]  eip_q,
    output logic [31:0]  retired_count,
    output logic         err
);

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_GPR  = 2'd1;
    localparam logic [1:0] KIND_MEM  = 2'd2;
    localparam logic [1:0] KIND_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM0   = 2'd1,
        MEM1   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Descriptor legality: reserved kind, high-byte of a non-ABCD register, byte-high memory.
    function automatic logic desc_illegal(input logic [1:0] kind, input logic [2:0] sel,
                                          input logic [1:0] width);
        logic bad;
        case (kind)
            KIND_NONE: bad = 1'b0;
            KIND_GPR:  bad = (width == 2'd1) && sel[2];
            KIND_MEM:  bad = (width == 2'd1);
            KIND_RSVD: bad = 1'b1;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic mem_ok(input logic [1:0] kind, input logic [1:0] width);
        return (kind == KIND_MEM) && (width != 2'd1);
    endfunction

    function automatic logic [31:0] mem_data(input logic [1:0] width, input logic [31:0] opnd);
        logic [31:0] d;
        case (width)
            2'd0:    d = {24'd0, opnd[7:0]};
            2'd2:    d = {16'd0, opnd[15:0]};
            2'd3:    d = opnd;
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    function automatic logic [3:0] mem_mask(input logic [1:0] width);
        logic [3:0] m;
        case (width)
            2'd0:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Merges one destination into the register file; high-byte forms address AH..BH via sel[1:0].
    function automatic logic [255:0] gpr_merge(input logic [255:0] file, input logic [1:0] kind,
                                               input logic [2:0] sel, input logic [1:0] width,
                                               input logic [31:0] data);
        logic [255:0] res;
        logic [31:0]  cur;
        logic [2:0]   idx;
        logic [7:0]   base;
        res  = file;
        idx  = (width == 2'd1) ? {1'b0, sel[1:0]} : sel;
        base = {idx, 5'd0};
        cur  = file[base +: 32];
        case (width)
            2'd0:    cur[7:0]  = data[7:0];
            2'd1:    cur[15:8] = data[7:0];
            2'd2:    cur[15:0] = data[15:0];
            2'd3:    cur       = data;
            default: cur       = file[base +: 32];
        endcase
        if ((kind == KIND_GPR) && !desc_illegal(kind, sel, width)) begin
            res[base +: 32] = cur;
        end else begin
            res = file;
        end
        return res;
    endfunction

    state_t         state_r, state_s;
    logic [31:0]    opnd0_r, opnd1_r, eflags_in_r, next_eip_r;
    logic [1:0]     d0_kind_r, d0_width_r, d1_kind_r, d1_width_r;
    logic [2:0]     d0_sel_r, d1_sel_r;
    logic [31:0]    d1_addr_r;
    logic           mem_valid_r, mem_valid_s;
    logic [31:0]    mem_addr_r, mem_addr_s, mem_data_r, mem_data_s;
    logic [3:0]     mem_mask_r, mem_mask_s;
    logic [255:0]   gpr_r, gpr_commit_s;
    logic [31:0]    eflags_r, eip_r, retired_r;
    logic           err_r, illegal_s, handshake_s;

    assign in_ready      = (state_r == IDLE) && !rst;
    assign handshake_s   = in_valid && in_ready;
    assign mem_wr_valid  = mem_valid_r;
    assign mem_wr_addr   = mem_addr_r;
    assign mem_wr_data   = mem_data_r;
    assign mem_wr_mask   = mem_mask_r;
    assign gpr_flat      = gpr_r;
    assign eflags_q      = eflags_r;
    assign eip_q         = eip_r;
    assign retired_count = retired_r;
    assign err           = err_r;

    // Next-state and next memory-port request; the request is held until accepted.
    always_comb begin
        state_s     = state_r;
        mem_valid_s = mem_valid_r;
        mem_addr_s  = mem_addr_r;
        mem_data_s  = mem_data_r;
        mem_mask_s  = mem_mask_r;
        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    if (mem_ok(in_dest0_kind, in_dest0_width)) begin
                        state_s     = MEM0;
                        mem_valid_s = 1'b1;
                        mem_addr_s  = in_dest0_addr;
                        mem_data_s  = mem_data(in_dest0_width, in_opnd0_w);
                        mem_mask_s  = mem_mask(in_dest0_width);
                    end else if (mem_ok(in_dest1_kind, in_dest1_width)) begin
                        state_s     = MEM1;
                        mem_valid_s = 1'b1;
                        mem_addr_s  = in_dest1_addr;
                        mem_data_s  = mem_data(in_dest1_width, in_opnd1_w);
                        mem_mask_s  = mem_mask(in_dest1_width);
                    end else begin
                        state_s = COMMIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MEM0: begin
                if (mem_wr_ready) begin
                    if (mem_ok(d1_kind_r, d1_width_r)) begin
                        state_s     = MEM1;
                        mem_valid_s = 1'b1;
                        mem_addr_s  = d1_addr_r;
                        mem_data_s  = mem_data(d1_width_r, opnd1_r);
                        mem_mask_s  = mem_mask(d1_width_r);
                    end else begin
                        state_s     = COMMIT;
                        mem_valid_s = 1'b0;
                        mem_addr_s  = 32'd0;
                        mem_data_s  = 32'd0;
                        mem_mask_s  = 4'd0;
                    end
                end else begin
                    state_s = MEM0;
                end
            end
            MEM1: begin
                if (mem_wr_ready) begin
                    state_s     = COMMIT;
                    mem_valid_s = 1'b0;
                    mem_addr_s  = 32'd0;
                    mem_data_s  = 32'd0;
                    mem_mask_s  = 4'd0;
                end else begin
                    state_s = MEM1;
                end
            end
            COMMIT: begin
                state_s = IDLE;
            end
            default: begin
                state_s     = IDLE;
                mem_valid_s = 1'b0;
                mem_addr_s  = 32'd0;
                mem_data_s  = 32'd0;
                mem_mask_s  = 4'd0;
            end
        endcase
    end

    // Register-file image after applying dest0 then dest1, so dest1 wins on shared bytes.
    always_comb begin
        gpr_commit_s = gpr_merge(gpr_r, d0_kind_r, d0_sel_r, d0_width_r, opnd0_r);
        gpr_commit_s = gpr_merge(gpr_commit_s, d1_kind_r, d1_sel_r, d1_width_r, opnd1_r);
        illegal_s    = desc_illegal(d0_kind_r, d0_sel_r, d0_width_r)
                     | desc_illegal(d1_kind_r, d1_sel_r, d1_width_r);
    end

    // State, memory port, bundle capture and architectural commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_data_r  <= 32'd0;
            mem_mask_r  <= 4'd0;
            opnd0_r     <= 32'd0;
            opnd1_r     <= 32'd0;
            eflags_in_r <= 32'd0;
            next_eip_r  <= 32'd0;
            d0_kind_r   <= KIND_NONE;
            d0_sel_r    <= 3'd0;
            d0_width_r  <= 2'd0;
            d1_kind_r   <= KIND_NONE;
            d1_sel_r    <= 3'd0;
            d1_width_r  <= 2'd0;
            d1_addr_r   <= 32'd0;
            gpr_r       <= 256'd0;
            eflags_r    <= RESET_EFLAGS;
            eip_r       <= RESET_EIP;
            retired_r   <= 32'd0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            mem_valid_r <= mem_valid_s;
            mem_addr_r  <= mem_addr_s;
            mem_data_r  <= mem_data_s;
            mem_mask_r  <= mem_mask_s;
            if (handshake_s) begin
                opnd0_r     <= in_opnd0_w;
                opnd1_r     <= in_opnd1_w;
                eflags_in_r <= in_eflags;
                next_eip_r  <= in_next_eip;
                d0_kind_r   <= in_dest0_kind;
                d0_sel_r    <= in_dest0_sel;
                d0_width_r  <= in_dest0_width;
                d1_kind_r   <= in_dest1_kind;
                d1_sel_r    <= in_dest1_sel;
                d1_width_r  <= in_dest1_width;
                d1_addr_r   <= in_dest1_addr;
            end
            if (state_r == COMMIT) begin
                gpr_r     <= gpr_commit_s;
                eflags_r  <= eflags_in_r;
                eip_r     <= next_eip_r;
                retired_r <= retired_r + 32'd1;
                if (illegal_s) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_commit.sv
// Directed bench for writeback_commit: register, memory, overlap, illegal and reset cases.
module tb_writeback_commit;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [31:0]  in_opnd0_w, in_opnd1_w, in_eflags, in_next_eip;
    logic [1:0]   in_dest0_kind, in_dest0_width, in_dest1_kind, in_dest1_width;
    logic [2:0]   in_dest0_sel, in_dest1_sel;
    logic [31:0]  in_dest0_addr, in_dest1_addr;
    logic         mem_wr_valid, mem_wr_ready;
    logic [31:0]  mem_wr_addr, mem_wr_data;
    logic [3:0]   mem_wr_mask;
    logic [255:0] gpr_flat;
    logic [31:0]  eflags_q, eip_q, retired_count;
    logic         err;

    int           n_checks = 0;
    int           n_fail = 0;
    int           wr_cnt = 0;
    int           wr_base;
    logic [31:0]  log_addr [8];
    logic [31:0]  log_data [8];
    logic [3:0]   log_mask [8];
    logic [255:0] exp_gpr;

    writeback_commit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opnd0_w(in_opnd0_w), .in_opnd1_w(in_opnd1_w),
        .in_eflags(in_eflags), .in_next_eip(in_next_eip),
        .in_dest0_kind(in_dest0_kind), .in_dest0_sel(in_dest0_sel),
        .in_dest0_width(in_dest0_width), .in_dest0_addr(in_dest0_addr),
        .in_dest1_kind(in_dest1_kind), .in_dest1_sel(in_dest1_sel),
        .in_dest1_width(in_dest1_width), .in_dest1_addr(in_dest1_addr),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
        .gpr_flat(gpr_flat), .eflags_q(eflags_q), .eip_q(eip_q),
        .retired_count(retired_count), .err(err)
    );

    always #5 clk = ~clk;

    // Logs every accepted memory write.
    always @(posedge clk) begin
        if (mem_wr_valid && mem_wr_ready) begin
            log_addr[wr_cnt % 8] <= mem_wr_addr;
            log_data[wr_cnt % 8] <= mem_wr_data;
            log_mask[wr_cnt % 8] <= mem_wr_mask;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a bundle at a falling edge and returns just after the handshake edge.
    task automatic send(input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] fl,
                        input logic [31:0] ne,
                        input logic [1:0] k0, input logic [2:0] s0, input logic [1:0] w0,
                        input logic [31:0] a0,
                        input logic [1:0] k1, input logic [2:0] s1, input logic [1:0] w1,
                        input logic [31:0] a1);
        int n = 0;
        in_opnd0_w = o0; in_opnd1_w = o1; in_eflags = fl; in_next_eip = ne;
        in_dest0_kind = k0; in_dest0_sel = s0; in_dest0_width = w0; in_dest0_addr = a0;
        in_dest1_kind = k1; in_dest1_sel = s1; in_dest1_width = w1; in_dest1_addr = a1;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("send_timeout", {255'd0, in_ready}, 256'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", {255'd0, in_ready}, 256'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mem_wr_ready = 1'b0;
        in_opnd0_w = 32'd0; in_opnd1_w = 32'd0; in_eflags = 32'd0; in_next_eip = 32'd0;
        in_dest0_kind = 2'd0; in_dest0_sel = 3'd0; in_dest0_width = 2'd0; in_dest0_addr = 32'd0;
        in_dest1_kind = 2'd0; in_dest1_sel = 3'd0; in_dest1_width = 2'd0; in_dest1_addr = 32'd0;
        exp_gpr = 256'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", {255'd0, in_ready}, 256'd0);
        check_eq("rst_mem_valid", {255'd0, mem_wr_valid}, 256'd0);
        rst = 1'b0;
        #1;
        check_eq("rst_eip", eip_q, 256'h0);
        check_eq("rst_eflags", eflags_q, 256'h2);
        check_eq("rst_gpr", gpr_flat, 256'd0);
        check_eq("rst_err", {255'd0, err}, 256'd0);
        check_eq("rst_retired", retired_count, 256'd0);
        check_eq("rst_ready_after", {255'd0, in_ready}, 256'd1);
        @(negedge clk);

        // EAX dword, with one-cycle commit latency
        send(32'hDEADBEEF, 32'd0, 32'h46, 32'h1005, 2'd1, 3'd0, 2'd3, 32'd0,
             2'd0, 3'd0, 2'd0, 32'd0);
        @(negedge clk);
        check_eq("b1_before_commit", gpr_flat[31:0], 256'h0);
        wait_idle();
        exp_gpr[31:0] = 32'hDEADBEEF;
        check_eq("b1_gpr", gpr_flat, exp_gpr);
        check_eq("b1_eip", eip_q, 256'h1005);
        check_eq("b1_eflags", eflags_q, 256'h46);
        check_eq("b1_retired", retired_count, 256'd1);

        // AH write
        send(32'h12, 32'd0, 32'h46, 32'h1007, 2'd1, 3'd0, 2'd1, 32'd0,
             2'd0, 3'd0, 2'd0, 32'd0);
        wait_idle();
        exp_gpr[31:0] = 32'hDEAD12EF;
        check_eq("b2_gpr", gpr_flat, exp_gpr);
        check_eq("b2_eip", eip_q, 256'h1007);
        check_eq("b2_retired", retired_count, 256'd2);

        // Memory word with 3 stall cycles, then ESP
        wr_base = wr_cnt;
        send(32'hAABBCCDD, 32'h0FFC, 32'h86, 32'h1010, 2'd2, 3'd0, 2'd2, 32'h2000,
             2'd1, 3'd4, 2'd3, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("b3_valid", {255'd0, mem_wr_valid}, 256'd1);
            check_eq("b3_addr", mem_wr_addr, 256'h2000);
            check_eq("b3_data", mem_wr_data, 256'h0000CCDD);
            check_eq("b3_mask", {252'd0, mem_wr_mask}, 256'h3);
            check_eq("b3_esp_hold", gpr_flat[159:128], 256'h0);
            if (i == 3) mem_wr_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        mem_wr_ready = 1'b0;
        @(negedge clk);
        check_eq("b3_valid_drop", {255'd0, mem_wr_valid}, 256'd0);
        check_eq("b3_esp_pre", gpr_flat[159:128], 256'h0);
        check_eq("b3_wr_count", wr_cnt - wr_base, 256'd1);
        wait_idle();
        exp_gpr[159:128] = 32'h0FFC;
        check_eq("b3_gpr", gpr_flat, exp_gpr);
        check_eq("b3_eip", eip_q, 256'h1010);
        check_eq("b3_retired", retired_count, 256'd3);

        // Overlapping EDX writes, dest1 wins
        send(32'h11223344, 32'h0000AAAA, 32'h2, 32'h1020, 2'd1, 3'd2, 2'd3, 32'd0,
             2'd1, 3'd2, 2'd2, 32'd0);
        wait_idle();
        exp_gpr[95:64] = 32'h1122AAAA;
        check_eq("b4_gpr", gpr_flat, exp_gpr);
        check_eq("b4_retired", retired_count, 256'd4);

        // Illegal descriptors: high byte of sel5, reserved kind
        send(32'h55, 32'h77, 32'h202, 32'h2000, 2'd1, 3'd5, 2'd1, 32'd0,
             2'd3, 3'd1, 2'd3, 32'd0);
        wait_idle();
        check_eq("b5_err", {255'd0, err}, 256'd1);
        check_eq("b5_gpr", gpr_flat, exp_gpr);
        check_eq("b5_eip", eip_q, 256'h2000);
        check_eq("b5_eflags", eflags_q, 256'h202);
        check_eq("b5_retired", retired_count, 256'd5);

        // Two memory writes to the same address, in order
        mem_wr_ready = 1'b1;
        wr_base = wr_cnt;
        send(32'h5A5A5A5A, 32'hCAFEF00D, 32'h3, 32'h3000, 2'd2, 3'd0, 2'd0, 32'h3000,
             2'd2, 3'd0, 2'd3, 32'h3000);
        wait_idle();
        mem_wr_ready = 1'b0;
        check_eq("b6_wr_count", wr_cnt - wr_base, 256'd2);
        check_eq("b6_w0_addr", log_addr[wr_base % 8], 256'h3000);
        check_eq("b6_w0_data", log_data[wr_base % 8], 256'h5A);
        check_eq("b6_w0_mask", {252'd0, log_mask[wr_base % 8]}, 256'h1);
        check_eq("b6_w1_data", log_data[(wr_base + 1) % 8], 256'hCAFEF00D);
        check_eq("b6_w1_mask", {252'd0, log_mask[(wr_base + 1) % 8]}, 256'hF);
        check_eq("b6_gpr", gpr_flat, exp_gpr);
        check_eq("b6_err_sticky", {255'd0, err}, 256'd1);
        check_eq("b6_retired", retired_count, 256'd6);

        // Reset while stalled in MEM0
        send(32'h99, 32'h1234, 32'h8D7, 32'h5000, 2'd2, 3'd0, 2'd3, 32'h4000,
             2'd1, 3'd1, 2'd3, 32'd0);
        @(negedge clk);
        check_eq("b7_valid_pre", {255'd0, mem_wr_valid}, 256'd1);
        rst = 1'b1;
        #1;
        check_eq("b7_valid_rst", {255'd0, mem_wr_valid}, 256'd0);
        check_eq("b7_addr_rst", mem_wr_addr, 256'h0);
        check_eq("b7_ready_rst", {255'd0, in_ready}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("b7_gpr", gpr_flat, 256'd0);
        check_eq("b7_eip", eip_q, 256'h0);
        check_eq("b7_eflags", eflags_q, 256'h2);
        check_eq("b7_retired", retired_count, 256'd0);
        check_eq("b7_err", {255'd0, err}, 256'd0);
        repeat (3) @(negedge clk);
        check_eq("b7_no_commit", eip_q, 256'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
